axi_st_patgen: RTL and testbench
================================

Name: axi_st_patgen

Overview:
- AXI4-Stream pattern-generator stage directly downstream of the CSR block.
- Consumes csr_patgen_en, csr_patgen_sel, csr_patgen_cnt and csr_cntuspatt_en, and drives the leader-side AXI-ST transmit interface.
- Returns first-beat and last-beat snapshots plus valid flags to the CSR inputs data_in_first, data_in_first_valid, data_in_last and data_in_last_valid for software compare.

Parameters:
DATA_W, 512, tdata width in bits; multiple of 32
NWORDS, DATA_W/32, derived local; 32-bit words per beat

Ports:
clk  in  1  stream clock
rst_n  in  1  reset, asynchronous, active-low
csr_patgen_en  in  1  run enable; rising edge starts a run
csr_patgen_sel  in  2  pattern select
csr_patgen_cnt  in  9  beats per run (count mode)
csr_cntuspatt_en  in  1  1 = continuous mode; cnt ignored
tdata  out  DATA_W  stream data
tvalid  out  1  stream valid
tready  in  1  stream ready
tlast  out  1  final beat of a count-mode run
tkeep  out  DATA_W/8  constant all-ones
data_in_first  out  DATA_W  data of first accepted beat
data_in_first_valid  out  1  sticky; first-beat snapshot is valid
data_in_last  out  DATA_W  data of most recently accepted beat
data_in_last_valid  out  1  sticky; a run has ended and data_in_last is final
busy  out  1  state == RUN
beat_cnt  out  16  accepted beats in current run; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - tdata, data_in_first, data_in_last, beat_cnt: all 0.
  - tvalid, tlast, busy, both valid flags: 0.
  - State: IDLE. LFSR: 32'h0000_0001.
- Start detect: en_q is csr_patgen_en registered once; start = en & ~en_q. Configuration is sampled at start and held for the whole run.
- States and transitions:
  - IDLE: on start, clear beat_cnt, both valid flags, data_in_first and data_in_last; reseed the LFSR.
    - Count mode with cnt == 0: go to DONE immediately; no beat is issued and data_in_last_valid is set.
    - Otherwise: go to RUN, with tvalid = 1 on the next cycle.
  - RUN: a beat is accepted when tvalid & tready.
    - On each accepted beat: beat_cnt increments; the beat index i and the LFSR advance.
    - First accepted beat: data_in_first <= tdata; data_in_first_valid <= 1.
    - Every accepted beat: data_in_last <= tdata.
  - DONE: tvalid = 0. Return to IDLE when csr_patgen_en == 0.
- Leaving RUN:
  - Count mode: the beat with i == cnt-1 carries tlast = 1. Its acceptance sets data_in_last_valid and moves to DONE.
  - Continuous mode: tlast is always 0. When csr_patgen_en falls, finish the beat in flight, then set data_in_last_valid and go to DONE.
  - Count-mode abort (en falls mid-run): same as continuous; tlast is not asserted.
- AXI rule: once tvalid is high, tdata and tlast hold stable until accepted. tvalid never drops without a handshake.
- Throughput: one beat per cycle while tready is high. No bubbles between beats.
- Patterns, by sel, for beat index i and word k in [0, NWORDS):
  - 0, INCR: word k = i*NWORDS + k, modulo 2^32.
  - 1, LFSR: every word = 32-bit Galois LFSR state.
    - Taps: polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003.
    - Seed 1. State advances once per accepted beat.
  - 2, WALK1: only bit (i mod DATA_W) of tdata is set.
  - 3, FIXED: even i → every word 32'hA5A5_5A5A; odd i → every word 32'h5A5A_A5A5.
- The beat index wraps naturally. beat_cnt saturates and never wraps.
- A start edge while in RUN or DONE is ignored (en must first return to 0).
- Asynchronous reset mid-run: outputs take reset values immediately and the stream is abandoned.

Decomposition:
- Package axi_st_patgen_pkg holds:
  - sel encodings PAT_INCR, PAT_LFSR, PAT_WALK1, PAT_FIXED;
  - state enum IDLE, RUN, DONE;
  - LFSR_SEED and LFSR_TAPS;
  - FIXED_EVEN and FIXED_ODD.
- One sub-module, axi_st_patgen_lfsr: 32-bit Galois LFSR with ports clk, rst_n, seed_load and advance.

Test Plan:
- sel=0, cnt=4, tready=1, pulse en → 4 consecutive beats; beat0 word0=0, word15=15; beat3 word0=48; tlast only on beat3; data_in_last word0=48; both valid flags = 1; beat_cnt=4.
- sel=3, cnt=3, tready toggling 1,0,0,1,... → tdata/tvalid/tlast stable during stalls; data_in_first words all 32'hA5A5_5A5A, data_in_last words all 32'hA5A5_5A5A (i=2).
- sel=1, cnt=2 → beat0 words = 32'h0000_0001, beat1 words = 32'h8020_0003; data_in_first word0 = 32'h0000_0001.
- Continuous, sel=2, tready=1, en high for 10 accepted beats then low during beat 10 → that beat completes, no tlast, beat_cnt=11; data_in_last has only bit 10 set.
- cnt=0, count mode → no tvalid ever; DONE reached; data_in_first_valid=0, data_in_last_valid=1.
- rst_n low mid-run at beat 5 with tvalid=1 → tvalid=0, beat_cnt=0, state IDLE immediately; a new en edge restarts at i=0.

Source files
------------

// File: rtl/axi_st_patgen_pkg.sv
// Shared encodings and constants for the AXI4-Stream pattern generator.
// Also holds the Galois LFSR step used by the generator and its LFSR sub-module.
package axi_st_patgen_pkg;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_WALK1 = 2'd2,
    PAT_FIXED = 2'd3
  } pat_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_SEED  = 32'h0000_0001;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] FIXED_EVEN = 32'hA5A5_5A5A;
  localparam logic [31:0] FIXED_ODD  = 32'h5A5A_A5A5;

  // Right-shifting Galois form: the LSB falling out selects the tap mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/axi_st_patgen_if.sv
// AXI4-Stream transmit bundle between the pattern generator and its follower.
interface axi_st_patgen_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [DATA_W/8-1:0] tkeep;

  modport master (output tdata, tvalid, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/axi_st_patgen_lfsr.sv
// 32-bit Galois LFSR; reseeds on seed_load, otherwise steps once per advance.
module axi_st_patgen_lfsr
  import axi_st_patgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = LFSR_SEED;
    end else if (advance) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/axi_st_patgen.sv
// AXI4-Stream pattern generator driven by CSR run controls; captures first and
// last accepted beats for software compare.
module axi_st_patgen
  import axi_st_patgen_pkg::*;
#(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_patgen_en,
  input  logic [1:0]        csr_patgen_sel,
  input  logic [8:0]        csr_patgen_cnt,
  input  logic              csr_cntuspatt_en,
  axi_st_patgen_if.master   axis,
  output logic [DATA_W-1:0] data_in_first,
  output logic              data_in_first_valid,
  output logic [DATA_W-1:0] data_in_last,
  output logic              data_in_last_valid,
  output logic              busy,
  output logic [15:0]       beat_cnt
);

  localparam int NWORDS = DATA_W / 32;

  state_e            state_q, state_d;
  logic              en_q;
  pat_sel_e          sel_q, sel_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              cont_q, cont_d;
  logic              stop_q, stop_d;
  logic [31:0]       idx_q, idx_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [DATA_W-1:0] first_q, first_d;
  logic              first_valid_q, first_valid_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              last_valid_q, last_valid_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;

  logic        start;
  logic        accept;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic [31:0] lfsr_state;
  logic [31:0] idx_inc;

  assign start   = csr_patgen_en & ~en_q;
  assign accept  = tvalid_q & axis.tready;
  assign idx_inc = idx_q + 32'd1;

  function automatic logic [DATA_W-1:0] pattern(input pat_sel_e sel,
                                                input logic [31:0] idx,
                                                input logic [31:0] lfsr);
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] one;
    d      = '0;
    one    = '0;
    one[0] = 1'b1;
    for (int k = 0; k < NWORDS; k++) begin
      case (sel)
        PAT_INCR:  d[k*32 +: 32] = idx * 32'(NWORDS) + 32'(k);
        PAT_LFSR:  d[k*32 +: 32] = lfsr;
        PAT_FIXED: d[k*32 +: 32] = idx[0] ? FIXED_ODD : FIXED_EVEN;
        default:   d[k*32 +: 32] = '0;
      endcase
    end
    if (sel == PAT_WALK1) begin
      d = one << (idx % 32'(DATA_W));
    end
    return d;
  endfunction

  axi_st_patgen_lfsr u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (lfsr_load),
    .advance   (lfsr_adv),
    .state     (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      sel_q         <= PAT_INCR;
      cnt_q         <= '0;
      cont_q        <= 1'b0;
      stop_q        <= 1'b0;
      idx_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      first_q       <= '0;
      first_valid_q <= 1'b0;
      last_q        <= '0;
      last_valid_q  <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= csr_patgen_en;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      cont_q        <= cont_d;
      stop_q        <= stop_d;
      idx_q         <= idx_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      first_q       <= first_d;
      first_valid_q <= first_valid_d;
      last_q        <= last_d;
      last_valid_q  <= last_valid_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  // A run ends on the tlast beat, or on the first handshake after en has dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (!csr_cntuspatt_en && csr_patgen_cnt == 9'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (tlast_q || stop_q || !csr_patgen_en)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!csr_patgen_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    cont_d        = cont_q;
    stop_d        = stop_q;
    idx_d         = idx_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    first_d       = first_q;
    first_valid_d = first_valid_q;
    last_d        = last_q;
    last_valid_d  = last_valid_q;
    beat_cnt_d    = beat_cnt_q;
    lfsr_load     = 1'b0;
    lfsr_adv      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d         = pat_sel_e'(csr_patgen_sel);
          cnt_d         = csr_patgen_cnt;
          cont_d        = csr_cntuspatt_en;
          stop_d        = 1'b0;
          idx_d         = '0;
          beat_cnt_d    = '0;
          first_d       = '0;
          first_valid_d = 1'b0;
          last_d        = '0;
          last_valid_d  = 1'b0;
          lfsr_load     = 1'b1;
          if (state_d == RUN) begin
            tvalid_d = 1'b1;
            tdata_d  = pattern(pat_sel_e'(csr_patgen_sel), 32'd0, LFSR_SEED);
            tlast_d  = !csr_cntuspatt_en && csr_patgen_cnt == 9'd1;
          end else begin
            last_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!csr_patgen_en) begin
          stop_d = 1'b1;
        end
        if (accept) begin
          beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
          idx_d      = idx_inc;
          lfsr_adv   = 1'b1;
          last_d     = tdata_q;
          if (!first_valid_q) begin
            first_d       = tdata_q;
            first_valid_d = 1'b1;
          end
          if (state_d == DONE) begin
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
            last_valid_d = 1'b1;
          end else begin
            // Next beat's LFSR word is one step ahead of the word now on the bus.
            tdata_d = pattern(sel_q, idx_inc, lfsr_step(lfsr_state));
            tlast_d = !cont_q && (idx_inc == {23'd0, cnt_q} - 32'd1);
          end
        end
      end
      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  assign axis.tdata          = tdata_q;
  assign axis.tvalid         = tvalid_q;
  assign axis.tlast          = tlast_q;
  assign axis.tkeep          = '1;
  assign data_in_first       = first_q;
  assign data_in_first_valid = first_valid_q;
  assign data_in_last        = last_q;
  assign data_in_last_valid  = last_valid_q;
  assign busy                = (state_q == RUN);
  assign beat_cnt            = beat_cnt_q;

endmodule

// File: tb/tb_axi_st_patgen.sv
// Scoreboard bench for axi_st_patgen: directed runs push expected beats, a
// negedge monitor pops and compares every handshake and checks stall stability.
module tb_axi_st_patgen;

  localparam int DW = 512;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    sel;
  logic [8:0]    cnt;
  logic          cont;
  logic [DW-1:0] first;
  logic          firstValid;
  logic [DW-1:0] lastData;
  logic          lastValid;
  logic          busy;
  logic [15:0]   beatCnt;

  int checks   = 0;
  int failures = 0;
  int accCount = 0;

  beat_t         expQ[$];
  logic          prevStall;
  logic [DW-1:0] prevData;
  logic          prevLast;

  axi_st_patgen_if #(.DATA_W(DW)) axis ();

  axi_st_patgen #(.DATA_W(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .csr_patgen_en       (en),
    .csr_patgen_sel      (sel),
    .csr_patgen_cnt      (cnt),
    .csr_cntuspatt_en    (cont),
    .axis                (axis),
    .data_in_first       (first),
    .data_in_first_valid (firstValid),
    .data_in_last        (lastData),
    .data_in_last_valid  (lastValid),
    .busy                (busy),
    .beat_cnt            (beatCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fillWord(input logic [31:0] w);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = w;
    return d;
  endfunction

  function automatic logic [DW-1:0] incrBeat(input int i);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'(i * 16 + k);
    return d;
  endfunction

  function automatic logic [DW-1:0] walkBeat(input int i);
    logic [DW-1:0] d;
    d = DW'(1) << i;
    return d;
  endfunction

  task automatic pushBeat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    expQ.push_back(b);
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [8:0] c, input logic cm);
    sel  = s;
    cnt  = c;
    cont = cm;
    en   = 1'b1;
  endtask

  task automatic waitLastValid(input int budget, output int cycles);
    cycles = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (lastValid) return;
    end
    checkOutput("last_valid_timeout", DW'(lastValid), DW'(1));
  endtask

  task automatic waitAccepted(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (accCount >= target) return;
    end
    checkOutput("accept_timeout", DW'(accCount), DW'(target));
  endtask

  task automatic endRun();
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", DW'(expQ.size()), DW'(0));
    checkOutput("idle_busy", DW'(busy), DW'(0));
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_tvalid", DW'(axis.tvalid), DW'(1));
        checkOutput("stall_tdata", axis.tdata, prevData);
        checkOutput("stall_tlast", DW'(axis.tlast), DW'(prevLast));
      end
      if (axis.tvalid && axis.tready) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=none", axis.tdata);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_data", axis.tdata, e.data);
          checkOutput("beat_tlast", DW'(axis.tlast), DW'(e.last));
        end
        accCount++;
      end
      prevStall = axis.tvalid && !axis.tready;
      prevData  = axis.tdata;
      prevLast  = axis.tlast;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic readyPat[4];
    readyPat[0] = 1'b1;
    readyPat[1] = 1'b0;
    readyPat[2] = 1'b0;
    readyPat[3] = 1'b1;
    en          = 1'b0;
    sel         = 2'd0;
    cnt         = 9'd0;
    cont        = 1'b0;
    axis.tready = 1'b0;
    prevStall   = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset values");
    checkOutput("rst_tvalid", DW'(axis.tvalid), DW'(0));
    checkOutput("rst_tlast", DW'(axis.tlast), DW'(0));
    checkOutput("rst_tdata", axis.tdata, DW'(0));
    checkOutput("rst_tkeep", DW'(axis.tkeep), {(DW/8){1'b1}});
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_beat_cnt", DW'(beatCnt), DW'(0));
    checkOutput("rst_first", first, DW'(0));
    checkOutput("rst_last", lastData, DW'(0));
    checkOutput("rst_first_valid", DW'(firstValid), DW'(0));
    checkOutput("rst_last_valid", DW'(lastValid), DW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] INCR count=4");
    axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) pushBeat(incrBeat(i), i == 3);
    applyStimulus(2'd0, 9'd4, 1'b0);
    waitLastValid(50, cyc);
    checkOutput("incr_latency", DW'(cyc), DW'(5));
    checkOutput("incr_first_w0", DW'(first[31:0]), DW'(0));
    checkOutput("incr_first_w15", DW'(first[511:480]), DW'(15));
    checkOutput("incr_last_w0", DW'(lastData[31:0]), DW'(48));
    checkOutput("incr_last", lastData, incrBeat(3));
    checkOutput("incr_first_valid", DW'(firstValid), DW'(1));
    checkOutput("incr_last_valid", DW'(lastValid), DW'(1));
    checkOutput("incr_beat_cnt", DW'(beatCnt), DW'(4));
    endRun();

    $display("[TB] FIXED count=3 with stalls");
    pushBeat(fillWord(32'hA5A5_5A5A), 1'b0);
    pushBeat(fillWord(32'h5A5A_A5A5), 1'b0);
    pushBeat(fillWord(32'hA5A5_5A5A), 1'b1);
    applyStimulus(2'd3, 9'd3, 1'b0);
    cyc = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      axis.tready = readyPat[n % 4];
      cyc++;
      if (lastValid) break;
    end
    checkOutput("fixed_done", DW'(lastValid), DW'(1));
    axis.tready = 1'b1;
    checkOutput("fixed_first", first, fillWord(32'hA5A5_5A5A));
    checkOutput("fixed_last", lastData, fillWord(32'hA5A5_5A5A));
    checkOutput("fixed_beat_cnt", DW'(beatCnt), DW'(3));
    endRun();

    $display("[TB] LFSR count=2");
    pushBeat(fillWord(32'h0000_0001), 1'b0);
    pushBeat(fillWord(32'h8020_0003), 1'b1);
    applyStimulus(2'd1, 9'd2, 1'b0);
    waitLastValid(50, cyc);
    checkOutput("lfsr_first_w0", DW'(first[31:0]), DW'(32'h0000_0001));
    checkOutput("lfsr_last", lastData, fillWord(32'h8020_0003));
    endRun();

    $display("[TB] WALK1 continuous");
    accCount = 0;
    for (int i = 0; i <= 10; i++) pushBeat(walkBeat(i), 1'b0);
    applyStimulus(2'd2, 9'd0, 1'b1);
    waitAccepted(10, 100);
    en = 1'b0;
    waitLastValid(20, cyc);
    checkOutput("walk_stop_latency", DW'(cyc), DW'(1));
    checkOutput("walk_beat_cnt", DW'(beatCnt), DW'(11));
    checkOutput("walk_last", lastData, walkBeat(10));
    checkOutput("walk_first", first, walkBeat(0));
    checkOutput("walk_first_valid", DW'(firstValid), DW'(1));
    endRun();

    $display("[TB] count=0");
    applyStimulus(2'd0, 9'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("zero_tvalid", DW'(axis.tvalid), DW'(0));
    checkOutput("zero_busy", DW'(busy), DW'(0));
    checkOutput("zero_first_valid", DW'(firstValid), DW'(0));
    checkOutput("zero_last_valid", DW'(lastValid), DW'(1));
    checkOutput("zero_beat_cnt", DW'(beatCnt), DW'(0));
    endRun();

    $display("[TB] reset mid-run");
    accCount = 0;
    for (int i = 0; i < 20; i++) pushBeat(incrBeat(i), i == 19);
    applyStimulus(2'd0, 9'd20, 1'b0);
    waitAccepted(5, 100);
    checkOutput("prerst_tvalid", DW'(axis.tvalid), DW'(1));
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    checkOutput("midrst_tvalid", DW'(axis.tvalid), DW'(0));
    checkOutput("midrst_beat_cnt", DW'(beatCnt), DW'(0));
    checkOutput("midrst_busy", DW'(busy), DW'(0));
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pushBeat(incrBeat(0), 1'b0);
    pushBeat(incrBeat(1), 1'b1);
    applyStimulus(2'd0, 9'd2, 1'b0);
    waitLastValid(50, cyc);
    checkOutput("restart_first", first, incrBeat(0));
    checkOutput("restart_last", lastData, incrBeat(1));
    checkOutput("restart_beat_cnt", DW'(beatCnt), DW'(2));
    endRun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
